// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared state type, default sizes and width helper for the APB round-robin arbiter
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int NREQ_DEF    = 4;
  localparam int AW_DEF      = 8;
  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 15;

  // Never returns 0 so that a 1-requester or TIMEOUT=0 build still gets a legal vector width.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter_rr_pick.sv
// rtl/apb_rr_arbiter_rr_pick.sv - rotate-priority encoder: first eligible requester at or above ptr, wrapping
module rr_pick
  import apb_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = clog2_safe(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   index
);

  // Walk offsets from farthest to nearest so the nearest eligible slot is the last one written.
  always_comb begin : pick
    int slot;
    valid = 1'b0;
    index = '0;
    slot  = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      slot = (int'(ptr) + off) % NREQ;
      if (eligible[slot]) begin
        valid = 1'b1;
        index = slot[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - shares one APB master port between NREQ requesters, round-robin, with stall timeout
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               req_write,
  input  logic [NREQ*AW-1:0]            req_addr,
  input  logic [NREQ*DW-1:0]            req_wdata,
  output logic [NREQ-1:0]               done,
  output logic                          err,
  output logic [DW-1:0]                 rdata,
  output logic [clog2_safe(NREQ)-1:0]   owner,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite_e,
  output logic [AW-1:0]                 paddr,
  output logic [DW-1:0]                 pdata,
  input  logic [DW-1:0]                 prdata,
  input  logic                          pready
);

  localparam int             OW     = clog2_safe(NREQ);
  localparam int             CW     = clog2_safe(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT);
  localparam logic [OW-1:0]  LAST   = OW'(NREQ - 1);

  state_t          state;
  logic [OW-1:0]   ptr;
  logic [CW-1:0]   count;
  logic [NREQ-1:0] eligible;
  logic            pick_valid;
  logic [OW-1:0]   pick_index;

  // A requester whose done is showing has not yet had a chance to drop req.
  assign eligible = req & ~done;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (OW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .valid    (pick_valid),
    .index    (pick_index)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      count    <= '0;
      done     <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      owner    <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite_e <= 1'b0;
      paddr    <= '0;
      pdata    <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner    <= pick_index;
            paddr    <= req_addr[pick_index*AW +: AW];
            pdata    <= req_wdata[pick_index*DW +: DW];
            pwrite_e <= req_write[pick_index];
            psel     <= 1'b1;
            penable  <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          count   <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready wins over an expiring count, so a late ready is still a clean completion.
          if (pready || (TIMEOUT != 0 && count == TO_VAL)) begin
            if (pready && !pwrite_e) begin
              rdata <= prdata;
            end
            done[owner] <= 1'b1;
            err         <= ~pready;
            ptr         <= (owner == LAST) ? '0 : owner + 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Shares one APB master port between NREQ local requesters using round-robin arbitration.
- Sequences the APB SETUP/ACCESS protocol for each transfer and honours slave wait states (pready).
- Aborts a transfer with an error when the slave stalls longer than a configurable limit.
- Sits between bus-master agents (DMA, CPU bridge, test drivers) and the APB slave side.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 8, address width.
- DW, 8, data width.
- TIMEOUT, 15, max ACCESS-phase cycles with pready=0 before abort; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester transfer request; held high until its done pulse.
- req_write  in  NREQ  per-requester direction: 1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data; requester i at [i*DW +: DW].
- done  out  NREQ  one-cycle completion pulse to the owning requester.
- err  out  1  valid with done; 1 = transfer aborted by timeout.
- rdata  out  DW  read data captured at completion; valid with done, held until the next completion.
- owner  out  clog2(NREQ)  index of the current or last granted requester.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite_e  out  1  APB direction.
- paddr  out  AW  APB address.
- pdata  out  DW  APB write data.
- prdata  in  DW  APB read data.
- pready  in  1  APB slave ready.

Behaviour:
- Reset (reset=0 at a clock edge): state goes to IDLE. All outputs are 0: psel, penable, pwrite_e, paddr, pdata, done, err, rdata, owner. The round-robin pointer and timeout counter are 0.
- Reset mid-transfer aborts immediately. No done pulse is issued for the aborted transfer.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible set = req & ~done, so a requester that just completed cannot win in the same cycle.
  - If the eligible set is non-empty, pick the first set bit searching upward from ptr, wrapping modulo NREQ.
  - Latch that requester's addr, wdata and write into paddr, pdata, pwrite_e. Set owner = index. Go to SETUP.
  - If the eligible set is empty, stay in IDLE with psel=0 and penable=0.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS next cycle. Clear the timeout counter.
- ACCESS: psel=1, penable=1.
  - If pready=1: capture rdata=prdata (reads only; rdata is unchanged on writes). Next cycle: done[owner]=1, err=0, ptr=(owner+1) mod NREQ, state IDLE.
  - Else if TIMEOUT!=0 and count==TIMEOUT: next cycle: done[owner]=1, err=1, ptr advances, state IDLE.
  - Else: count+1, stay in ACCESS.
  - pready=1 in the same cycle as count==TIMEOUT counts as a normal completion (err=0).
- APB outputs stay stable from SETUP through the end of ACCESS. Requester inputs are ignored after the latch.
- Dropping req mid-transfer has no effect: the transfer completes and done still pulses.
- In the done cycle, psel=0 and penable=0 (IDLE).
- Latency: req seen in IDLE at cycle N gives SETUP at N+1 and ACCESS at N+2. With pready=1 at N+2, done is at N+3.
- Minimum 3 cycles per transfer. Back-to-back transfers from different requesters restart SETUP at N+4.
- done is one-hot or zero. err is 0 whenever done is 0.

Decomposition:
- Package apb_arb_pkg:
  - state typedef enum {IDLE, SETUP, ACCESS}.
  - Default NREQ/AW/DW constants.
  - Function clog2_safe for the owner and counter widths.
- Sub-module rr_pick:
  - Combinational rotate-priority encoder.
  - Inputs: eligible mask, ptr. Outputs: valid, index.
  - The FSM and datapath latches stay in apb_rr_arbiter.

Test Plan:
- Single write: req[1]=1, write, addr=0x24, wdata=0xA5, pready tied 1. Expect SETUP at N+1 (psel=1, penable=0, paddr=0x24, pdata=0xA5, pwrite_e=1), ACCESS at N+2, done=4'b0010 with err=0 at N+3.
- Read with 2 wait states: req[2] read, addr=0x10, pready=0 for 2 ACCESS cycles then 1 with prdata=0x3C. Expect ACCESS held for 3 cycles with stable APB outputs, then done[2]=1 and rdata=0x3C.
- Round-robin fairness: req=4'b1111 held continuously, each re-raised after its done. Expect grant order 0,1,2,3,0, owner matching, and no requester granted twice in a row.
- Timeout: TIMEOUT=15, pready held 0. Expect abort after 16 ACCESS cycles with done[owner]=1, err=1, rdata unchanged, and the next requester granted afterwards.
- Timeout boundary: pready=1 exactly in the cycle count==TIMEOUT. Expect err=0 and normal completion.
- Reset mid-ACCESS: reset=0 for one edge during a stalled read. Expect all outputs 0 on the next cycle and no done pulse. After reset=1, a pending req[3] is served as the first grant with ptr=0 (search order 0..3).
